mmio_uart_tx: RTL

- Memory-mapped console transmitter on the CPU data-memory port, decoded at the 0x001xxxxx MMIO window.
- Accepts byte stores from the memory-access stage, buffers them in a FIFO and serialises them as 8N1 UART frames on a single line.
- Returns status on loads, so firmware can poll before writing.
- Serves as the output half of the debug console alongside the ST/LD monitors.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 39 +++
 rtl/mmio_uart_tx.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS fields, FSM states and frame lengths for mmio_uart_tx.
// UART_TX_PARITY_EN selects the 8E1 frame with an even-parity bit.
package uart_pkg;
  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_DIVISOR = 4'h8;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;
  localparam int ST_COUNT = 8;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN  = 1'b1;
  localparam int   FRAME_BITS = 11;
`else
  localparam logic PARITY_EN  = 1'b0;
  localparam int   FRAME_BITS = 10;
`endif
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push is refused when full as seen before any same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i & !full_o;
  assign do_pop  = pop_i & !empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO console transmitter; buffers byte stores and serialises them as UART frames.
// UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] RESET_DIV  = 16'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t POST_DATA = PARITY;
`else
  localparam tx_state_t POST_DATA = STOP;
`endif
  tx_state_t state_q, state_d;
  logic [15:0] div_q, fdiv_q, fdiv_d, cnt_q, cnt_d, div_eff;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d, fifo_dout;
  logic [31:0] rdata_q, rdata_d, status;
  logic [CW-1:0] count;
  logic [3:0] off;
  logic ovf_q, hit, push, load, last, full, empty, unused_wdata;
  assign hit          = addr[31:4] == BASE_ADDR[31:4];
  assign off          = addr[3:0];
  assign push         = we & hit & (off == OFF_TXDATA);
  assign div_eff      = (div_q == 16'd0) ? 16'd1 : div_q;
  assign last         = cnt_q == 16'd0;
  assign busy         = (state_q != IDLE) | !empty;
  assign rdata        = rdata_q;
  assign unused_wdata = ^wdata[31:16];
  assign tx = (state_q == START)  ? 1'b0 :
              (state_q == DATA)   ? byte_q[bit_q] :
              (state_q == PARITY) ? ^byte_q : 1'b1;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push_i(push), .din_i(wdata[7:0]), .pop_i(load),
    .dout_o(fifo_dout), .full_o(full), .empty_o(empty), .count_o(count)
  );
  always_comb begin
    status           = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf_q;
    status[ST_PAR]   = PARITY_EN;
    status[ST_COUNT +: 8] = 8'(count);
    rdata_d = rdata_q;
    if (re & hit)
      rdata_d = (off == OFF_STATUS) ? status : (off == OFF_DIVISOR) ? {16'd0, div_q} : 32'd0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? fdiv_q - 16'd1 : cnt_q - 16'd1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    fdiv_d  = fdiv_q;
    case (state_q)
      START:  state_d = last ? DATA : START;
      DATA: begin
        bit_d   = last ? bit_q + 3'd1 : bit_q;
        state_d = (last && bit_q == 3'(DATA_BITS - 1)) ? POST_DATA : DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_d = last ? STOP : PARITY;
`endif
      STOP:   state_d = last ? IDLE : STOP;
      default: begin
        state_d = IDLE;
        cnt_d   = cnt_q;
      end
    endcase
    // Pop and latch byte plus divisor together so a frame never sees a mid-frame DIVISOR write
    load = !empty & ((state_q == IDLE) | ((state_q == STOP) & last));
    if (load) begin
      state_d = START;
      byte_d  = fifo_dout;
      fdiv_d  = div_eff;
      cnt_d   = div_eff - 16'd1;
      bit_d   = 3'd0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      fdiv_q  <= RESET_DIV;
      div_q   <= RESET_DIV;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      fdiv_q  <= fdiv_d;
      rdata_q <= rdata_d;
      div_q   <= (we & hit & (off == OFF_DIVISOR)) ? wdata[15:0] : div_q;
      ovf_q   <= (push & full) | (ovf_q & !(we & hit & (off == OFF_STATUS) & wdata[ST_OVF]));
    end
endmodule
